// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned ADDR_W    = 7;

  // Bus level for an acknowledge bit: low is ACK, released/high is NACK.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK
  } i2c_slave_state_t;

endpackage

// File: rtl/i2c_slave_if.sv
// Local-side byte handshake between the I2C target and its peripheral logic.
interface i2c_slave_if;
  import i2c_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_done;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_req;
  logic              rd_nack;
  logic              busy;

  modport slave (
    output rx_data, rx_done, tx_req, rd_nack, busy,
    input  tx_data
  );

  modport master (
    input  rx_data, rx_done, tx_req, rd_nack, busy,
    output tx_data
  );

endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus line, with edge pulses.
module i2c_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic meta;
  logic q_prev;

  // Synchronizer chain plus one-sample history for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= RST_VAL;
      q      <= RST_VAL;
      q_prev <= RST_VAL;
    end else begin
      meta   <= d;
      q      <= meta;
      q_prev <= q;
    end
  end

  assign rise_c = q & ~q_prev;
  assign fall_c = ~q & q_prev;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: START/STOP detection, 7-bit address match, byte receive and transmit.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h3C
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SCL,
  inout  wire        SDA,
  i2c_slave_if.slave bus
);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BYTE_W - 1);

  logic scl_q, scl_rise_c, scl_fall_c;
  logic sda_q, sda_rise_c, sda_fall_c;
  logic start_c, stop_c;

  i2c_slave_state_t      state, state_nxt;
  logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [BYTE_W-1:0]     shift_reg, shift_nxt, sr_in_c;
  logic                  rw, rw_nxt;
  logic                  phase, phase_nxt;
  logic                  sda_lvl, sda_lvl_nxt;
  logic [BYTE_W-1:0]     rx_data, rx_data_nxt;
  logic                  rx_done, rx_done_nxt;
  logic                  tx_req, tx_req_nxt;
  logic                  rd_nack, rd_nack_nxt;
  logic                  busy, busy_nxt;

  i2c_sync_edge #(.RST_VAL(1'b1)) u_scl_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (SCL),
    .q      (scl_q),
    .rise_c (scl_rise_c),
    .fall_c (scl_fall_c)
  );

  i2c_sync_edge #(.RST_VAL(1'b1)) u_sda_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (SDA),
    .q      (sda_q),
    .rise_c (sda_rise_c),
    .fall_c (sda_fall_c)
  );

  // SCL high now and not just risen means it was high last sample too.
  assign start_c = sda_fall_c & scl_q & ~scl_rise_c;
  assign stop_c  = sda_rise_c & scl_q & ~scl_rise_c;
  assign sr_in_c = {shift_reg[BYTE_W-2:0], sda_q};

  // Open-drain pad: only ever pull low or release.
  assign SDA = sda_lvl ? 1'bz : 1'b0;

  assign bus.rx_data = rx_data;
  assign bus.rx_done = rx_done;
  assign bus.tx_req  = tx_req;
  assign bus.rd_nack = rd_nack;
  assign bus.busy    = busy;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rw        <= 1'b0;
      phase     <= 1'b0;
      sda_lvl   <= 1'b1;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      tx_req    <= 1'b0;
      rd_nack   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
      rw        <= rw_nxt;
      phase     <= phase_nxt;
      sda_lvl   <= sda_lvl_nxt;
      rx_data   <= rx_data_nxt;
      rx_done   <= rx_done_nxt;
      tx_req    <= tx_req_nxt;
      rd_nack   <= rd_nack_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and output logic; bus conditions override every state.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    rw_nxt      = rw;
    phase_nxt   = phase;
    sda_lvl_nxt = sda_lvl;
    rx_data_nxt = rx_data;
    rx_done_nxt = 1'b0;
    tx_req_nxt  = 1'b0;
    rd_nack_nxt = 1'b0;
    busy_nxt    = busy;

    if (start_c) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = '0;
      phase_nxt   = 1'b0;
      sda_lvl_nxt = 1'b1;
      busy_nxt    = 1'b0;
    end else if (stop_c) begin
      state_nxt   = IDLE;
      phase_nxt   = 1'b0;
      sda_lvl_nxt = 1'b1;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise_c) begin
            shift_nxt   = sr_in_c;
            bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == BIT_LAST) begin
              if (sr_in_c[BYTE_W-1:1] == SLAVE_ADDR) begin
                state_nxt = ADDR_ACK;
                rw_nxt    = sr_in_c[0];
                phase_nxt = 1'b0;
                busy_nxt  = 1'b1;
              end else begin
                state_nxt = IDLE;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall_c) begin
            if (!phase) begin
              sda_lvl_nxt = I2C_ACK;
              phase_nxt   = 1'b1;
            end else begin
              phase_nxt = 1'b0;
              if (rw) begin
                shift_nxt   = bus.tx_data;
                tx_req_nxt  = 1'b1;
                sda_lvl_nxt = bus.tx_data[BYTE_W-1];
                bit_cnt_nxt = '0;
                state_nxt   = READ;
              end else begin
                sda_lvl_nxt = 1'b1;
                state_nxt   = WRITE;
              end
            end
          end
        end
        WRITE: begin
          if (scl_rise_c) begin
            shift_nxt   = sr_in_c;
            bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == BIT_LAST) begin
              rx_data_nxt = sr_in_c;
              rx_done_nxt = 1'b1;
              phase_nxt   = 1'b0;
              state_nxt   = WRITE_ACK;
            end
          end
        end
        WRITE_ACK: begin
          if (scl_fall_c) begin
            if (!phase) begin
              sda_lvl_nxt = I2C_ACK;
              phase_nxt   = 1'b1;
            end else begin
              sda_lvl_nxt = 1'b1;
              phase_nxt   = 1'b0;
              state_nxt   = WRITE;
            end
          end
        end
        READ: begin
          if (scl_fall_c) begin
            if (bit_cnt == BIT_LAST) begin
              sda_lvl_nxt = 1'b1;
              bit_cnt_nxt = '0;
              phase_nxt   = 1'b0;
              state_nxt   = READ_ACK;
            end else begin
              shift_nxt   = {shift_reg[BYTE_W-2:0], 1'b0};
              sda_lvl_nxt = shift_reg[BYTE_W-2];
              bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        READ_ACK: begin
          if (scl_rise_c) begin
            if (sda_q == I2C_NACK) begin
              rd_nack_nxt = 1'b1;
              busy_nxt    = 1'b0;
              sda_lvl_nxt = 1'b1;
              state_nxt   = IDLE;
            end else begin
              phase_nxt = 1'b1;
            end
          end else if (scl_fall_c && phase) begin
            shift_nxt   = bus.tx_data;
            tx_req_nxt  = 1'b1;
            sda_lvl_nxt = bus.tx_data[BYTE_W-1];
            bit_cnt_nxt = '0;
            phase_nxt   = 1'b0;
            state_nxt   = READ;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged bus master, scoreboards for received and transmitted bytes.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int unsigned T_Q = 20;

  typedef struct {
    logic [7:0]  addr;
    int unsigned n;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        ack;
  } wvec_t;

  logic clk       = 1'b0;
  logic reset_n   = 1'b0;
  logic scl       = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda_bus;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave_if bus_if ();

  i2c_slave #(.SLAVE_ADDR(7'h3C)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .SCL    (scl),
    .SDA    (sda_bus),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned tx_req_cnt = 0;
  int unsigned rd_nack_cnt = 0;
  logic [7:0] rxq [$];
  logic [7:0] txsrc [$];
  logic [7:0] rdq [$];
  wvec_t wv [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Advance n cycles, scoring DUT output pulses and presenting the next tx byte.
  task automatic tick(input int unsigned n);
    logic [7:0] e;
    repeat (n) begin
      @(negedge clk);
      if (bus_if.rx_done) begin
        if (rxq.size() == 0) begin
          n_chk++;
          $display("FAIL rx_done_unexpected: rx_data 0x%0h with nothing expected", bus_if.rx_data);
        end else begin
          e = rxq.pop_front();
          chk("rx_data", 32'(bus_if.rx_data), 32'(e));
        end
      end
      if (bus_if.tx_req) begin
        tx_req_cnt++;
        if (txsrc.size() == 0) begin
          n_chk++;
          $display("FAIL tx_req_unexpected: tx_req pulse with no byte queued");
        end else begin
          void'(txsrc.pop_front());
        end
      end
      if (bus_if.rd_nack) rd_nack_cnt++;
      bus_if.tx_data = (txsrc.size() != 0) ? txsrc[0] : 8'h00;
    end
  endtask

  task automatic start_cond();
    m_sda_low = 1'b1; tick(2 * T_Q);
    scl = 1'b0;       tick(T_Q);
  endtask

  task automatic rep_start();
    m_sda_low = 1'b0; tick(T_Q);
    scl = 1'b1;       tick(2 * T_Q);
    m_sda_low = 1'b1; tick(2 * T_Q);
    scl = 1'b0;       tick(T_Q);
  endtask

  task automatic stop_cond();
    m_sda_low = 1'b1; tick(T_Q);
    scl = 1'b1;       tick(2 * T_Q);
    m_sda_low = 1'b0; tick(2 * T_Q);
  endtask

  task automatic put_bit(input logic b);
    m_sda_low = ~b; tick(T_Q);
    scl = 1'b1;     tick(2 * T_Q);
    scl = 1'b0;     tick(T_Q);
  endtask

  task automatic get_bit(output logic b);
    m_sda_low = 1'b0; tick(T_Q);
    scl = 1'b1;       tick(T_Q);
    b = sda_bus;      tick(T_Q);
    scl = 1'b0;       tick(T_Q);
  endtask

  task automatic put_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(input logic nack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(nack);
  endtask

  task automatic write_txn(input logic [7:0] addr, input int unsigned n,
                           input logic [7:0] d0, input logic [7:0] d1, input logic exp_ack);
    logic a;
    logic [7:0] d;
    start_cond();
    put_byte(addr, a);
    chk("addr_ack", 32'(a), 32'(exp_ack ? I2C_ACK : I2C_NACK));
    chk("busy_after_addr", 32'(bus_if.busy), 32'(exp_ack));
    for (int j = 0; j < int'(n); j++) begin
      d = (j == 0) ? d0 : d1;
      if (exp_ack) rxq.push_back(d);
      put_byte(d, a);
      chk("data_ack", 32'(a), 32'(exp_ack ? I2C_ACK : I2C_NACK));
    end
    stop_cond();
    chk("busy_after_stop", 32'(bus_if.busy), 32'd0);
    chk("rx_pending", 32'(rxq.size()), 32'd0);
    chk("sda_released", 32'(sda_bus), 32'd1);
  endtask

  initial begin
    logic a;
    logic [7:0] v;
    int unsigned tx0, nk0;

    wv[0] = '{8'h78, 2, 8'hA5, 8'h5A, 1'b1};
    wv[1] = '{8'h52, 1, 8'hFF, 8'h00, 1'b0};
    wv[2] = '{8'h78, 1, 8'h00, 8'h00, 1'b1};
    wv[3] = '{8'h78, 1, 8'hFF, 8'h00, 1'b1};
    wv[4] = '{8'h7A, 1, 8'h12, 8'h00, 1'b0};
    wv[5] = '{8'h3C, 1, 8'h34, 8'h00, 1'b0};

    // Reset state.
    tick(3);
    chk("rst_sda", 32'(sda_bus), 32'd1);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_rx_data", 32'(bus_if.rx_data), 32'd0);
    chk("rst_pulses", 32'({bus_if.rx_done, bus_if.tx_req, bus_if.rd_nack}), 32'd0);
    reset_n = 1'b1;
    tick(5);

    // Write transactions from the vector table.
    for (int k = 0; k < 6; k++) begin
      write_txn(wv[k].addr, wv[k].n, wv[k].d0, wv[k].d1, wv[k].ack);
      tick(T_Q);
    end
    chk("rx_data_last", 32'(bus_if.rx_data), 32'h0000_00FF);

    // Read two bytes: ACK the first, NACK the second.
    tx0 = tx_req_cnt; nk0 = rd_nack_cnt;
    txsrc.push_back(8'hC3); txsrc.push_back(8'h3C);
    rdq.push_back(8'hC3);   rdq.push_back(8'h3C);
    tick(2);
    start_cond();
    put_byte(8'h79, a);
    chk("rd_addr_ack", 32'(a), 32'(I2C_ACK));
    get_byte(I2C_ACK, v);
    chk("rd_byte0", 32'(v), 32'(rdq.pop_front()));
    get_byte(I2C_NACK, v);
    chk("rd_byte1", 32'(v), 32'(rdq.pop_front()));
    tick(T_Q);
    chk("rd_tx_req_cnt", tx_req_cnt - tx0, 32'd2);
    chk("rd_nack_cnt", rd_nack_cnt - nk0, 32'd1);
    chk("rd_busy", 32'(bus_if.busy), 32'd0);
    chk("rd_sda_released", 32'(sda_bus), 32'd1);
    stop_cond();
    tick(T_Q);

    // Write then repeated START into a one-byte read.
    tx0 = tx_req_cnt;
    rxq.push_back(8'h11);
    txsrc.push_back(8'h96); rdq.push_back(8'h96);
    start_cond();
    put_byte(8'h78, a); chk("rs_addr_ack", 32'(a), 32'(I2C_ACK));
    put_byte(8'h11, a); chk("rs_data_ack", 32'(a), 32'(I2C_ACK));
    rep_start();
    chk("rs_state", 32'(dut.state), 32'(ADDR));
    chk("rs_busy", 32'(bus_if.busy), 32'd0);
    put_byte(8'h79, a); chk("rs_rd_addr_ack", 32'(a), 32'(I2C_ACK));
    get_byte(I2C_NACK, v);
    chk("rs_rd_byte", 32'(v), 32'(rdq.pop_front()));
    stop_cond();
    chk("rs_rx_data", 32'(bus_if.rx_data), 32'h0000_0011);
    chk("rs_tx_req_cnt", tx_req_cnt - tx0, 32'd1);
    tick(T_Q);

    // STOP after the fourth data bit abandons the byte.
    start_cond();
    put_byte(8'h78, a); chk("ab_addr_ack", 32'(a), 32'(I2C_ACK));
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    stop_cond();
    chk("ab_state", 32'(dut.state), 32'(IDLE));
    chk("ab_busy", 32'(bus_if.busy), 32'd0);
    chk("ab_sda", 32'(sda_bus), 32'd1);
    tick(T_Q);
    write_txn(8'h78, 1, 8'h22, 8'h00, 1'b1);
    tick(T_Q);

    // Reset while the address ACK is driven low.
    start_cond();
    for (int i = 7; i >= 0; i--) put_bit(v[0] == v[0] ? 1'((8'h78 >> i) & 8'h01) : 1'b0);
    m_sda_low = 1'b0;
    tick(T_Q);
    chk("ack_driven", 32'(sda_bus), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sda", 32'(sda_bus), 32'd1);
    chk("mid_rst_busy", 32'(bus_if.busy), 32'd0);
    chk("mid_rst_rx_data", 32'(bus_if.rx_data), 32'd0);
    tick(4);
    reset_n = 1'b1;
    tick(4);
    stop_cond();
    tick(T_Q);
    write_txn(8'h78, 1, 8'h33, 8'h00, 1'b1);
    chk("final_rx_data", 32'(bus_if.rx_data), 32'h0000_0033);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
